cw305_designstart_top: RTL and testbench

// - Top level of the CW305 trace-matcher target: USB byte-wide register front end plus 8 byte-masked 64-bit trace pattern matchers.
// - Trace bytes shift into a 64-bit window. Each enabled rule compares the window against its pattern/mask and raises a match pulse.
// - Match pulses drive the sticky flags, the match counter, the trigger output and the LEDs.
// - Single clock domain: usb_clk. rst is synchronous and active-high.

---
 rtl/cw305_designstart_top.sv | 208 ++++++++++++++++++++
 tb/tb_cw305_designstart_top.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cw305_designstart_top.sv
// cw305_designstart_top
//
// CW305 trace-matcher target. A byte-wide USB register front end configures
// up to eight byte-masked 64-bit pattern rules. Trace bytes shift into a
// 64-bit window, and each enabled rule that matches the window raises a
// one-cycle match pulse. The pulses feed sticky flags, a saturating match
// counter, the trigger output and the LEDs.
//
// Ports
//   usb_clk      sole clock
//   rst          synchronous active-high reset
//   usb_data     bidirectional USB data bus, driven only while usb_rdn is low
//   usb_addr     {register address, subbyte}
//   usb_rdn      read strobe (active-low)
//   usb_wrn      write strobe (active-low)
//   usb_cen      chip select (active-low)
//   trace_data   trace byte
//   trace_valid  trace_data is valid this cycle
//   match        per-rule registered match pulse
//   trigger      OR of all match bits
//   led1         any sticky matched flag set
//   led2         any rule enabled
//   led3         trigger
module cw305_designstart_top #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pNUM_RULES    = 8
) (
  input  logic                   usb_clk,
  input  logic                   rst,
  inout  wire  [7:0]             usb_data,
  input  logic [pADDR_WIDTH-1:0] usb_addr,
  input  logic                   usb_rdn,
  input  logic                   usb_wrn,
  input  logic                   usb_cen,
  input  logic [7:0]             trace_data,
  input  logic                   trace_valid,
  output logic [7:0]             match,
  output logic                   trigger,
  output logic                   led1,
  output logic                   led2,
  output logic                   led3
);

  localparam int REG_W = pADDR_WIDTH - pBYTECNT_SIZE;

  localparam logic [REG_W-1:0] ADDR_ENABLE  = REG_W'(8'h10);
  localparam logic [REG_W-1:0] ADDR_MATCHED = REG_W'(8'h11);
  localparam logic [REG_W-1:0] ADDR_COUNT   = REG_W'(8'h12);
  localparam logic [REG_W-1:0] ADDR_PATTERN = REG_W'(8'h20);
  localparam logic [REG_W-1:0] ADDR_MASK    = REG_W'(8'h28);
  localparam logic [REG_W-1:0] ADDR_SCRATCH = REG_W'(8'h30);

  localparam logic [pBYTECNT_SIZE-1:0] SUB_0 = pBYTECNT_SIZE'(0);
  localparam logic [pBYTECNT_SIZE-1:0] SUB_4 = pBYTECNT_SIZE'(4);
  localparam logic [pBYTECNT_SIZE-1:0] SUB_8 = pBYTECNT_SIZE'(8);

  // Pattern and mask registers are big-endian by subbyte: subbyte 0 is the MSB.
  function automatic logic [7:0] be_byte(input logic [63:0] v, input logic [2:0] s);
    return v[{~s, 3'b000} +: 8];
  endfunction

  // Scratch and count are little-endian by subbyte.
  function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] s);
    return v[{s, 3'b000} +: 8];
  endfunction

  logic [REG_W-1:0]         reg_addr_s;
  logic [pBYTECNT_SIZE-1:0] subbyte_s;
  logic [2:0]               rule_idx_s;
  logic                     rule_ok_s;

  logic wr_s, rd_s;
  logic sel_enable_s, sel_matched_s, sel_count_s;
  logic sel_pat_s, sel_mask_s, sel_scratch_s;

  logic [7:0]  enable_q;
  logic [7:0]  matched_q, matched_d;
  logic [31:0] count_q, count_d;
  logic [31:0] scratch_q;
  logic [63:0] pattern_q [pNUM_RULES];
  logic [63:0] mask_q    [pNUM_RULES];
  logic [63:0] win_q;
  logic        valid_d_q;
  logic [7:0]  match_q;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  hit_s;
  logic [7:0]  w1c_s;

  assign reg_addr_s = usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
  assign subbyte_s  = usb_addr[pBYTECNT_SIZE-1:0];
  assign rule_idx_s = reg_addr_s[2:0];

  // Strobe and register-select decode.
  always_comb begin
    wr_s          = ~usb_cen & ~usb_wrn;
    rd_s          = ~usb_cen & ~usb_rdn;
    rule_ok_s     = ({29'd0, rule_idx_s} < 32'(pNUM_RULES));
    sel_enable_s  = (reg_addr_s == ADDR_ENABLE)  && (subbyte_s == SUB_0);
    sel_matched_s = (reg_addr_s == ADDR_MATCHED) && (subbyte_s == SUB_0);
    sel_count_s   = (reg_addr_s == ADDR_COUNT)   && (subbyte_s < SUB_4);
    sel_scratch_s = (reg_addr_s == ADDR_SCRATCH) && (subbyte_s < SUB_4);
    sel_pat_s     = ({reg_addr_s[REG_W-1:3], 3'b000} == ADDR_PATTERN) && rule_ok_s
                    && (subbyte_s < SUB_8);
    sel_mask_s    = ({reg_addr_s[REG_W-1:3], 3'b000} == ADDR_MASK) && rule_ok_s
                    && (subbyte_s < SUB_8);
  end

  // Read data mux; anything unmapped reads as zero.
  always_comb begin
    rdata_d = 8'h00;
    if (sel_enable_s) begin
      rdata_d = enable_q;
    end else if (sel_matched_s) begin
      rdata_d = matched_q;
    end else if (sel_count_s) begin
      rdata_d = le_byte(count_q, subbyte_s[1:0]);
    end else if (sel_scratch_s) begin
      rdata_d = le_byte(scratch_q, subbyte_s[1:0]);
    end else if (sel_pat_s) begin
      rdata_d = be_byte(pattern_q[rule_idx_s], subbyte_s[2:0]);
    end else if (sel_mask_s) begin
      rdata_d = be_byte(mask_q[rule_idx_s], subbyte_s[2:0]);
    end else begin
      rdata_d = 8'h00;
    end
  end

  // Rule compare against the current window. Register values here are the
  // pre-write ones, so a same-cycle USB write only affects later compares.
  always_comb begin
    hit_s = 8'h00;
    for (int r = 0; r < pNUM_RULES; r++) begin
      hit_s[r] = enable_q[r] && (((win_q ^ pattern_q[r]) & ~mask_q[r]) == 64'h0);
    end
  end

  // Sticky flags and saturating counter next state. Set beats a same-cycle clear.
  always_comb begin
    if (wr_s && sel_matched_s) begin
      w1c_s = usb_data;
    end else begin
      w1c_s = 8'h00;
    end
    matched_d = (matched_q & ~w1c_s) | match_q;
    if ((|match_q) && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // USB-writable configuration registers and read-data capture.
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      enable_q  <= 8'h00;
      scratch_q <= 32'h0;
      rdata_q   <= 8'h00;
      for (int r = 0; r < pNUM_RULES; r++) begin
        pattern_q[r] <= 64'h0;
        mask_q[r]    <= 64'h0;
      end
    end else begin
      if (rd_s) begin
        rdata_q <= rdata_d;
      end
      if (wr_s && sel_enable_s) begin
        enable_q <= usb_data;
      end
      if (wr_s && sel_scratch_s) begin
        scratch_q[{subbyte_s[1:0], 3'b000} +: 8] <= usb_data;
      end
      if (wr_s && sel_pat_s) begin
        pattern_q[rule_idx_s][{~subbyte_s[2:0], 3'b000} +: 8] <= usb_data;
      end
      if (wr_s && sel_mask_s) begin
        mask_q[rule_idx_s][{~subbyte_s[2:0], 3'b000} +: 8] <= usb_data;
      end
    end
  end

  // Trace window, match pulse pipeline, sticky flags and counter.
  always_ff @(posedge usb_clk) begin
    if (rst) begin
      win_q     <= 64'h0;
      valid_d_q <= 1'b0;
      match_q   <= 8'h00;
      matched_q <= 8'h00;
      count_q   <= 32'h0;
    end else begin
      if (trace_valid) begin
        win_q <= {win_q[55:0], trace_data};
      end
      valid_d_q <= trace_valid;
      match_q   <= hit_s & {8{valid_d_q}};
      matched_q <= matched_d;
      count_q   <= count_d;
    end
  end

  assign usb_data = usb_rdn ? 8'hzz : rdata_q;
  assign match    = match_q;
  assign trigger  = |match_q;
  assign led1     = |matched_q;
  assign led2     = |enable_q;
  assign led3     = |match_q;

endmodule

// File: tb/tb_cw305_designstart_top.sv
// Directed testbench for cw305_designstart_top: USB register access, reset,
// pattern matching with and without masks, sticky-flag clear collision,
// trace gaps and bus turnaround.
module tb_cw305_designstart_top;

  logic        usb_clk = 1'b0;
  logic        rst;
  wire  [7:0]  usb_data;
  logic [20:0] usb_addr;
  logic        usb_rdn, usb_wrn, usb_cen;
  logic [7:0]  trace_data;
  logic        trace_valid;
  logic [7:0]  match;
  logic        trigger, led1, led2, led3;

  logic        drv_en;
  logic [7:0]  drv_val;

  int n_vec = 0;
  int n_err = 0;

  assign usb_data = drv_en ? drv_val : 8'hzz;

  always #5 usb_clk = ~usb_clk;

  cw305_designstart_top dut (
    .usb_clk     (usb_clk),
    .rst         (rst),
    .usb_data    (usb_data),
    .usb_addr    (usb_addr),
    .usb_rdn     (usb_rdn),
    .usb_wrn     (usb_wrn),
    .usb_cen     (usb_cen),
    .trace_data  (trace_data),
    .trace_valid (trace_valid),
    .match       (match),
    .trigger     (trigger),
    .led1        (led1),
    .led2        (led2),
    .led3        (led3)
  );

  // Drive a write strobe starting now; it is sampled at the next rising edge.
  task automatic usb_write_now(input logic [13:0] ra, input logic [6:0] sb, input logic [7:0] d);
    usb_addr = {ra, sb};
    drv_val  = d;
    drv_en   = 1'b1;
    usb_cen  = 1'b0;
    usb_wrn  = 1'b0;
    @(negedge usb_clk);
    usb_cen  = 1'b1;
    usb_wrn  = 1'b1;
    drv_en   = 1'b0;
  endtask

  task automatic usb_write(input logic [13:0] ra, input logic [6:0] sb, input logic [7:0] d);
    @(negedge usb_clk);
    usb_write_now(ra, sb, d);
  endtask

  task automatic usb_read(input logic [13:0] ra, input logic [6:0] sb, output logic [7:0] d);
    @(negedge usb_clk);
    usb_addr = {ra, sb};
    drv_en   = 1'b0;
    usb_cen  = 1'b0;
    usb_rdn  = 1'b0;
    @(posedge usb_clk);
    #1;
    d = usb_data;
    @(negedge usb_clk);
    usb_cen  = 1'b1;
    usb_rdn  = 1'b1;
  endtask

  task automatic write32(input logic [13:0] ra, input logic [31:0] v);
    for (int s = 0; s < 4; s++) usb_write(ra, 7'(s), v[s*8 +: 8]);
  endtask

  task automatic read32(input logic [13:0] ra, output logic [31:0] v);
    logic [7:0] b;
    for (int s = 0; s < 4; s++) begin
      usb_read(ra, 7'(s), b);
      v[s*8 +: 8] = b;
    end
  endtask

  task automatic write64(input logic [13:0] ra, input logic [63:0] v);
    for (int s = 0; s < 8; s++) usb_write(ra, 7'(s), v[(7-s)*8 +: 8]);
  endtask

  // Feed 8 bytes MSB first, with 'gap' invalid cycles between bytes.
  task automatic feed8(input logic [63:0] v, input int gap);
    for (int i = 0; i < 8; i++) begin
      @(negedge usb_clk);
      trace_data  = v[(7-i)*8 +: 8];
      trace_valid = 1'b1;
      if (i < 7) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge usb_clk);
          trace_valid = 1'b0;
          trace_data  = 8'hEE;
          n_vec++;
          if (match !== 8'h00) begin
            n_err++;
            $display("FAIL gap_match byte%0d: got %h expected 00", i, match);
          end
        end
      end
    end
  endtask

  // After the last byte of feed8: no pulse yet, then exp for one cycle, then 0.
  task automatic expect_match(input logic [7:0] exp, input string tag);
    @(negedge usb_clk);
    trace_valid = 1'b0;
    n_vec++;
    if (match !== 8'h00) begin
      n_err++; $display("FAIL %s_early: got %h expected 00", tag, match);
    end
    @(negedge usb_clk);
    n_vec++;
    if (match !== exp || trigger !== (|exp) || led3 !== (|exp)) begin
      n_err++;
      $display("FAIL %s_pulse: got match=%h trig=%b led3=%b expected %h", tag, match, trigger, led3, exp);
    end
    @(negedge usb_clk);
    n_vec++;
    if (match !== 8'h00) begin
      n_err++; $display("FAIL %s_late: got %h expected 00", tag, match);
    end
  endtask

  task automatic test_reset();
    logic [7:0]  b;
    logic [31:0] w;
    rst = 1'b1;
    repeat (2) @(negedge usb_clk);
    rst = 1'b0;
    n_vec++;
    if (match !== 8'h00 || trigger !== 1'b0 || led1 !== 1'b0 || led2 !== 1'b0 || led3 !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: got match=%h trig=%b leds=%b%b%b expected 00 0 000", match, trigger, led1, led2, led3);
    end
    usb_read(14'h10, 7'd0, b);
    n_vec++;
    if (b !== 8'h00) begin n_err++; $display("FAIL reset_enable: got %h expected 00", b); end
    read32(14'h12, w);
    n_vec++;
    if (w !== 32'h0) begin n_err++; $display("FAIL reset_count: got %h expected 00000000", w); end
  endtask

  task automatic test_scratch();
    logic [31:0] w;
    for (int i = 0; i < 10; i++) begin
      write32(14'h30, 32'h1234_5678 + 32'(i));
      read32(14'h30, w);
      n_vec++;
      if (w !== 32'h1234_5678 + 32'(i)) begin
        n_err++; $display("FAIL scratch_%0d: got %h expected %h", i, w, 32'h1234_5678 + 32'(i));
      end
    end
  endtask

  task automatic test_decode();
    logic [7:0] b;
    usb_write(14'h10, 7'd1, 8'hAA);
    usb_write(14'h10, 7'd0, 8'h3C);
    usb_read(14'h10, 7'd0, b);
    n_vec++;
    if (b !== 8'h3C) begin n_err++; $display("FAIL enable_rw: got %h expected 3c", b); end
    usb_read(14'h10, 7'd1, b);
    n_vec++;
    if (b !== 8'h00) begin n_err++; $display("FAIL enable_sub1: got %h expected 00", b); end
    usb_read(14'h13, 7'd0, b);
    n_vec++;
    if (b !== 8'h00) begin n_err++; $display("FAIL unmapped: got %h expected 00", b); end
    usb_read(14'h12, 7'd4, b);
    n_vec++;
    if (b !== 8'h00) begin n_err++; $display("FAIL count_sub4: got %h expected 00", b); end
    write64(14'h22, 64'h1122_3344_5566_7788);
    usb_read(14'h22, 7'd0, b);
    n_vec++;
    if (b !== 8'h11) begin n_err++; $display("FAIL pat_sub0: got %h expected 11", b); end
    usb_read(14'h22, 7'd7, b);
    n_vec++;
    if (b !== 8'h88) begin n_err++; $display("FAIL pat_sub7: got %h expected 88", b); end
    usb_write(14'h2B, 7'd0, 8'h77);
    usb_read(14'h2B, 7'd0, b);
    n_vec++;
    if (b !== 8'h77) begin n_err++; $display("FAIL mask_rw: got %h expected 77", b); end
  endtask

  task automatic test_reset_mid();
    logic [7:0]  b;
    logic [31:0] w;
    @(negedge usb_clk);
    trace_data  = 8'h5A;
    trace_valid = 1'b1;
    rst = 1'b1;
    usb_write_now(14'h10, 7'd0, 8'hFF);
    trace_valid = 1'b0;
    @(negedge usb_clk);
    rst = 1'b0;
    usb_read(14'h10, 7'd0, b);
    n_vec++;
    if (b !== 8'h00) begin n_err++; $display("FAIL rst_enable: got %h expected 00", b); end
    usb_read(14'h11, 7'd0, b);
    n_vec++;
    if (b !== 8'h00) begin n_err++; $display("FAIL rst_matched: got %h expected 00", b); end
    read32(14'h12, w);
    n_vec++;
    if (w !== 32'h0) begin n_err++; $display("FAIL rst_count: got %h expected 00000000", w); end
    read32(14'h30, w);
    n_vec++;
    if (w !== 32'h0) begin n_err++; $display("FAIL rst_scratch: got %h expected 00000000", w); end
    usb_read(14'h22, 7'd0, b);
    n_vec++;
    if (b !== 8'h00) begin n_err++; $display("FAIL rst_pattern2: got %h expected 00", b); end
    for (int r = 0; r < 8; r++) begin
      usb_read(14'h28 + 14'(r), 7'd0, b);
      n_vec++;
      if (b !== 8'h00) begin n_err++; $display("FAIL rst_mask%0d: got %h expected 00", r, b); end
    end
  endtask

  task automatic test_match_basic();
    logic [7:0]  b;
    logic [31:0] w;
    usb_write(14'h10, 7'd0, 8'hFF);
    write64(14'h20, 64'h0102_0304_0506_0708);
    feed8(64'h0102_0304_0506_0708, 0);
    expect_match(8'h01, "basic");
    usb_read(14'h11, 7'd0, b);
    n_vec++;
    if (b !== 8'h01) begin n_err++; $display("FAIL basic_matched: got %h expected 01", b); end
    read32(14'h12, w);
    n_vec++;
    if (w !== 32'd1) begin n_err++; $display("FAIL basic_count: got %h expected 00000001", w); end
    n_vec++;
    if (led1 !== 1'b1 || led2 !== 1'b1) begin
      n_err++; $display("FAIL basic_leds: got led1=%b led2=%b expected 1 1", led1, led2);
    end
  endtask

  task automatic test_masked();
    logic [7:0]  b;
    logic [31:0] w;
    usb_write(14'h10, 7'd0, 8'h02);
    write64(14'h21, 64'hAABB_0000_0000_0000);
    write64(14'h29, 64'h0000_FFFF_FFFF_FFFF);
    feed8(64'hAABB_1234_5678_9ABC, 0);
    expect_match(8'h02, "masked");
    usb_write(14'h10, 7'd0, 8'h00);
    feed8(64'hAABB_1234_5678_9ABC, 0);
    expect_match(8'h00, "disabled");
    read32(14'h12, w);
    n_vec++;
    if (w !== 32'd2) begin n_err++; $display("FAIL masked_count: got %h expected 00000002", w); end
    usb_read(14'h11, 7'd0, b);
    n_vec++;
    if (b !== 8'h03) begin n_err++; $display("FAIL masked_matched: got %h expected 03", b); end
  endtask

  task automatic test_w1c_collision();
    logic [7:0]  b;
    logic [31:0] w;
    usb_write(14'h11, 7'd0, 8'h03);
    usb_read(14'h11, 7'd0, b);
    n_vec++;
    if (b !== 8'h00) begin n_err++; $display("FAIL w1c_clear: got %h expected 00", b); end
    usb_write(14'h10, 7'd0, 8'h01);
    feed8(64'h0102_0304_0506_0708, 0);
    @(negedge usb_clk);
    trace_valid = 1'b0;
    @(negedge usb_clk);
    n_vec++;
    if (match !== 8'h01) begin n_err++; $display("FAIL coll_pulse: got %h expected 01", match); end
    usb_write_now(14'h11, 7'd0, 8'h01);
    usb_read(14'h11, 7'd0, b);
    n_vec++;
    if (b !== 8'h01) begin n_err++; $display("FAIL coll_set_wins: got %h expected 01", b); end
    usb_write(14'h11, 7'd0, 8'h01);
    usb_read(14'h11, 7'd0, b);
    n_vec++;
    if (b !== 8'h00 || led1 !== 1'b0) begin
      n_err++; $display("FAIL coll_clear: got %h led1=%b expected 00 0", b, led1);
    end
    read32(14'h12, w);
    n_vec++;
    if (w !== 32'd3) begin n_err++; $display("FAIL coll_count: got %h expected 00000003", w); end
  endtask

  task automatic test_gap();
    logic [31:0] w;
    // Window already holds rule 0's pattern; idle cycles must not pulse.
    for (int i = 0; i < 4; i++) begin
      @(negedge usb_clk);
      n_vec++;
      if (match !== 8'h00) begin n_err++; $display("FAIL idle_%0d: got %h expected 00", i, match); end
    end
    feed8(64'h0102_0304_0506_0708, 2);
    expect_match(8'h01, "gapped");
    read32(14'h12, w);
    n_vec++;
    if (w !== 32'd4) begin n_err++; $display("FAIL gap_count: got %h expected 00000004", w); end
  endtask

  task automatic test_bus();
    logic [7:0] b;
    usb_read(14'h30, 7'd0, b);
    n_vec++;
    if (b !== 8'h00) begin n_err++; $display("FAIL bus_read: got %h expected 00", b); end
    write32(14'h30, 32'h0000_00A5);
    usb_read(14'h30, 7'd0, b);
    n_vec++;
    if (b !== 8'hA5) begin n_err++; $display("FAIL bus_read2: got %h expected a5", b); end
    // With usb_rdn high the bench owns the bus; a DUT driver would corrupt it.
    @(negedge usb_clk);
    drv_val = 8'h5A;
    drv_en  = 1'b1;
    #1;
    n_vec++;
    if (usb_data !== 8'h5A) begin n_err++; $display("FAIL bus_release: got %h expected 5a", usb_data); end
    @(negedge usb_clk);
    drv_en = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    drv_en      = 1'b0;
    drv_val     = 8'h00;
    usb_addr    = 21'h0;
    usb_cen     = 1'b1;
    usb_rdn     = 1'b1;
    usb_wrn     = 1'b1;
    trace_data  = 8'h00;
    trace_valid = 1'b0;
    test_reset();
    test_scratch();
    test_decode();
    test_reset_mid();
    test_match_basic();
    test_masked();
    test_w1c_collision();
    test_gap();
    test_bus();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
